clk_div_sched: RTL and testbench

Programmable clock-divider controller. It generates a divided clock of any integer ratio N ≥ 2 with near-50% duty; odd ratios use a falling-edge half-cycle extension stage. It sequences ratio changes through a valid/ready configuration port, applies each new ratio only at a period boundary so the output never glitches, and starts and stops the output cleanly on `run`. It sits between the configuration/register logic and the downstream consumers of the divided clock and period tick.

---
 rtl/clk_div_sched.sv | 131 +++++++++++++
 tb/tb_clk_div_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_sched.sv
// Programmable integer clock divider (N >= 2, near-50% duty) with glitch-free
// ratio changes at period boundaries and clean start/stop on run.
module clk_div_sched #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pend_div;
    logic             run_q;
    logic             pos_hi;
    logic             neg_hi;
    logic             live;

    logic             accept;
    logic             bad_div;
    logic             wrap;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] half;

    // Handshake: a request transfers on any rising edge where cfg_valid and
    // cfg_ready are both 1; cfg_ready never depends on cfg_valid, and it drops
    // while a ratio change is pending so at most one change is in flight.
    assign cfg_ready = ~reset & (state != SWITCH);
    assign accept    = cfg_valid & cfg_ready;
    assign bad_div   = cfg_div < CNT_W'(2);
    assign wrap      = (cnt == cur_div - 1'b1);
    assign cnt_inc   = cnt + 1'b1;
    assign half      = cur_div >> 1;
    assign fsm_state = state;

    // live masks a stale neg_hi during the half cycle after a reset edge.
    assign clk_out = pos_hi | (neg_hi & live & cur_div[0]);

    always_ff @(negedge clk) begin
        if (reset) begin
            neg_hi <= 1'b0;
        end else begin
            neg_hi <= pos_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            pos_hi   <= 1'b0;
            tick     <= 1'b0;
            busy     <= 1'b0;
            cfg_err  <= 1'b0;
            run_q    <= 1'b0;
            live     <= 1'b0;
            cur_div  <= CNT_W'(DEFAULT_DIV);
            pend_div <= CNT_W'(DEFAULT_DIV);
        end else begin
            run_q   <= run;
            live    <= 1'b1;
            cfg_err <= accept & bad_div;
            case (state)
                IDLE: begin
                    if (accept && !bad_div) begin
                        cur_div <= cfg_div;
                    end
                    cnt <= '0;
                    if (run_q) begin
                        state  <= RUN;
                        pos_hi <= 1'b1;
                        tick   <= 1'b1;
                    end else begin
                        pos_hi <= 1'b0;
                        tick   <= 1'b0;
                    end
                end
                RUN, SWITCH: begin
                    if (wrap) begin
                        cnt    <= '0;
                        pos_hi <= run_q;
                        tick   <= run_q;
                        state  <= run_q ? RUN : IDLE;
                        if (state == SWITCH) begin
                            cur_div <= pend_div;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt    <= cnt_inc;
                        pos_hi <= (cnt_inc < half);
                        tick   <= 1'b0;
                    end
                    // An accept on the stopping wrap lands in IDLE, so apply it directly.
                    if (state == RUN && accept && !bad_div) begin
                        if (wrap && !run_q) begin
                            cur_div <= cfg_div;
                        end else begin
                            pend_div <= cfg_div;
                            busy     <= 1'b1;
                            state    <= SWITCH;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    pos_hi <= 1'b0;
                    tick   <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: directed scenarios plus random traffic, checked
// against a period/half-cycle reference model of the divider.
module tb_clk_div_sched;

  localparam int CNT_W = 8;
  localparam int DEF   = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             run = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic [CNT_W-1:0] cur_div;
  logic [1:0]       fsm_state;

  clk_div_sched #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .cur_div   (cur_div),
    .fsm_state (fsm_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: output is high for the first N of the 2N half-cycles of a period
  bit m_run_q = 0, m_active = 0, m_pending = 0, m_err = 0;
  int m_cnt = 0, m_cur = DEF, m_pend = DEF;

  // {tick, busy, err, cur[7:0], state[1:0], clk_first_half, clk_second_half}
  logic [14:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_edge();
    bit acc, good;
    logic [14:0] e;
    int st;
    if (reset) begin
      m_run_q = 0; m_active = 0; m_pending = 0; m_err = 0;
      m_cnt = 0; m_cur = DEF; m_pend = DEF;
    end else begin
      acc   = cfg_valid && !m_pending;
      good  = acc && (cfg_div >= 2);
      m_err = acc && (cfg_div < 2);
      if (!m_active) begin
        if (good) m_cur = cfg_div;
        if (m_run_q) begin
          m_active = 1;
          m_cnt = 0;
        end
      end else begin
        if (m_cnt == m_cur - 1) begin
          if (m_pending) begin
            m_cur = m_pend;
            m_pending = 0;
          end
          m_cnt = 0;
          m_active = m_run_q;
          if (good && !m_active) begin
            m_cur = cfg_div;
            good = 0;
          end
        end else begin
          m_cnt++;
        end
        if (good) begin
          m_pend = cfg_div;
          m_pending = 1;
        end
      end
      m_run_q = run;
    end
    st = !m_active ? 0 : (m_pending ? 2 : 1);
    e[14]   = m_active && (m_cnt == 0);
    e[13]   = m_pending;
    e[12]   = m_err;
    e[11:4] = m_cur[7:0];
    e[3:2]  = st[1:0];
    e[1]    = m_active && (2 * m_cnt < m_cur);
    e[0]    = m_active && (2 * m_cnt + 1 < m_cur);
    exp_q.push_back(e);
  endtask

  // driver task: one clk cycle with the given inputs, checked at both half-cycles
  task automatic step(input bit rst, input bit r, input bit v, input int d);
    logic [14:0] e;
    reset = rst;
    run = r;
    cfg_valid = v;
    cfg_div = d[CNT_W-1:0];
    #1 check("cfg_ready", cfg_ready, !rst && !m_pending);
    @(posedge clk);
    model_edge();
    #2;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("tick", tick, e[14]);
      check("busy", busy, e[13]);
      check("cfg_err", cfg_err, e[12]);
      check("cur_div", cur_div, e[11:4]);
      check("fsm_state", fsm_state, e[3:2]);
      check("clk_out_first_half", clk_out, e[1]);
      @(negedge clk);
      #2 check("clk_out_second_half", clk_out, e[0]);
    end
  endtask

  task automatic run_cycles(input int n, input bit r);
    for (int i = 0; i < n; i++) step(0, r, 0, 0);
  endtask

  initial begin
    int rr;
    int dd;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

    // default ratio 5
    run_cycles(22, 1);
    run_cycles(10, 0);

    // ratio 4 configured while idle
    step(0, 0, 1, 4);
    run_cycles(18, 1);

    // back to 5, then 7 requested mid-period while the 5-period runs
    step(0, 1, 1, 5);
    run_cycles(12, 1);
    while (m_cnt != 2) step(0, 1, 0, 0);
    step(0, 1, 1, 7);
    step(0, 1, 1, 9);
    run_cycles(24, 1);

    // invalid ratios
    step(0, 1, 1, 1);
    run_cycles(3, 1);
    step(0, 1, 1, 0);
    run_cycles(10, 1);

    // back to 5, drop run at cnt=1, then drop and re-raise before the wrap
    step(0, 1, 1, 5);
    run_cycles(16, 1);
    while (m_cnt != 0) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    run_cycles(12, 0);
    run_cycles(8, 1);
    while (m_cnt != 1) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    run_cycles(14, 1);

    // ratio 3, reset during the high phase
    step(0, 0, 0, 0);
    run_cycles(8, 0);
    step(0, 0, 1, 3);
    run_cycles(8, 1);
    while (m_cnt != 0) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    run_cycles(3, 0);
    run_cycles(12, 1);

    // random traffic
    rr = 1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0) rr = !rr;
      if ($urandom_range(0, 59) == 0) dd = 255;
      else if ($urandom_range(0, 3) == 0) dd = $urandom_range(0, 1);
      else dd = $urandom_range(2, 12);
      step($urandom_range(0, 299) == 0, rr[0], $urandom_range(0, 7) == 0, dd);
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
